response_packer: RTL and testbench



---
 rtl/response_packer_pkg.sv | 51 +++++
 rtl/response_encoder.sv | 35 +++
 rtl/response_packer.sv | 164 ++++++++++++++++
 tb/tb_response_packer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/response_packer_pkg.sv
// Purpose: shared response codes, FSM state encoding and state helpers for response_packer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional feature macro: RESPONSE_PACKER_CHECKSUM_EN adds the SEND_CHK/WAIT_CHK states.
package response_packer_pkg;

    // Response codes, indexed by the one-hot selector bit that produces them.
    localparam logic [7:0] CODE_ERR   = 8'h1F;  // bit 0, wins over every other bit
    localparam logic [7:0] CODE_SEL1  = 8'h07;
    localparam logic [7:0] CODE_SEL2  = 8'h09;
    localparam logic [7:0] CODE_SEL3  = 8'h08;
    localparam logic [7:0] CODE_SEL4  = 8'h0A;
    localparam logic [7:0] CODE_SEL5  = 8'h0B;
    localparam logic [7:0] CODE_MULTI = 8'hFF;  // illegal multi-bit selector

    typedef enum logic [2:0] {
        IDLE,
        SEND_CODE,
        WAIT_CODE,
        SEND_DATA,
        WAIT_DATA
`ifdef RESPONSE_PACKER_CHECKSUM_EN
        ,
        SEND_CHK,
        WAIT_CHK
`endif
    } state_t;

    function automatic logic is_wait(input state_t s);
        logic w;
        w = (s == WAIT_CODE) || (s == WAIT_DATA);
`ifdef RESPONSE_PACKER_CHECKSUM_EN
        w = w || (s == WAIT_CHK);
`endif
        return w;
    endfunction

    // State to enter once the byte being waited on has been sent.
    function automatic state_t after_wait(input state_t s);
        state_t n;
        case (s)
            WAIT_CODE: n = SEND_DATA;
`ifdef RESPONSE_PACKER_CHECKSUM_EN
            WAIT_DATA: n = SEND_CHK;
`endif
            default:   n = IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/response_encoder.sv
// Purpose: maps the one-hot response selector and payload to the frame code/data bytes.
// Latency: combinational.
// Backpressure: none.
// Ports: comandos/data_in (selector, payload) -> vld (selector non-zero), code, data_out.
module response_encoder
    import response_packer_pkg::*;
(
    input  logic [5:0] comandos,
    input  logic [7:0] data_in,
    output logic       vld,
    output logic [7:0] code,
    output logic [7:0] data_out
);

    always_comb begin
        vld      = |comandos;
        code     = CODE_MULTI;
        data_out = 8'h00;
        if (comandos[0]) begin
            // Error flag overrides whatever else is set; payload still passes.
            code     = CODE_ERR;
            data_out = data_in;
        end else begin
            case (comandos)
                6'b000010: begin code = CODE_SEL1; data_out = data_in; end
                6'b000100: begin code = CODE_SEL2; data_out = data_in; end
                6'b001000: begin code = CODE_SEL3; data_out = data_in; end
                6'b010000: begin code = CODE_SEL4; data_out = data_in; end
                6'b100000: begin code = CODE_SEL5; data_out = data_in; end
                default:   begin code = CODE_MULTI; data_out = 8'h00; end
            endcase
        end
    end

endmodule

// File: rtl/response_packer.sv
// Purpose: packs sensor results into UART frames {code, data[, code^data]} with a one-entry pending slot.
// Latency: first o_tx_dv 2 cycles after i_done when the transmitter is idle.
// Backpressure: holds in SEND_x while i_tx_busy; waits for i_tx_done per byte, aborts after TIMEOUT_CYCLES.
// Ports: i_Clock, i_Rst_n (async, active low); i_done/i_comandos/i_data from the sensor side;
//        i_tx_busy/i_tx_done and o_tx_dv/o_tx_byte to the UART; o_busy, o_overrun, o_timeout status.
// Optional feature macro: RESPONSE_PACKER_CHECKSUM_EN appends an XOR checksum byte.
module response_packer
    import response_packer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5_000_000,
    parameter int CNT_W          = 23
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_done,
    input  logic [5:0] i_comandos,
    input  logic [7:0] i_data,
    input  logic       i_tx_busy,
    input  logic       i_tx_done,
    output logic       o_tx_dv,
    output logic [7:0] o_tx_byte,
    output logic       o_busy,
    output logic       o_overrun,
    output logic       o_timeout
);

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    logic             enc_vld;
    logic [7:0]       enc_code, enc_data;
    logic             new_vld;

    state_t           state_q, state_d;
    logic [7:0]       code_q, code_d, data_q, data_d;
    logic             slot_vld_q, slot_vld_d;
    logic [7:0]       slot_code_q, slot_code_d, slot_data_q, slot_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             tx_dv_q, tx_dv_d, overrun_q, overrun_d, timeout_q, timeout_d;
    logic [7:0]       tx_byte_q, tx_byte_d;

    response_encoder u_enc (
        .comandos (i_comandos),
        .data_in  (i_data),
        .vld      (enc_vld),
        .code     (enc_code),
        .data_out (enc_data)
    );

    assign new_vld = i_done && enc_vld;
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        data_d      = data_q;
        slot_vld_d  = slot_vld_q;
        slot_code_d = slot_code_q;
        slot_data_d = slot_data_q;
        cnt_d       = '0;            // cleared everywhere except while counting in a WAIT state
        tx_dv_d     = 1'b0;
        tx_byte_d   = tx_byte_q;
        overrun_d   = 1'b0;
        timeout_d   = 1'b0;

        if (is_wait(state_q)) begin
            if (i_tx_done) begin
                state_d = after_wait(state_q);
            end else if (cnt_inc == TIMEOUT_VAL) begin
                // Counter would reach the limit on this edge: abort the frame.
                timeout_d = 1'b1;
                state_d   = IDLE;
            end else begin
                cnt_d = cnt_inc;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (slot_vld_q) begin
                        code_d     = slot_code_q;
                        data_d     = slot_data_q;
                        slot_vld_d = 1'b0;
                        state_d    = SEND_CODE;
                    end else if (new_vld) begin
                        code_d  = enc_code;
                        data_d  = enc_data;
                        state_d = SEND_CODE;
                    end
                end
                SEND_CODE: begin
                    if (!i_tx_busy) begin
                        tx_dv_d   = 1'b1;
                        tx_byte_d = code_q;
                        state_d   = WAIT_CODE;
                    end
                end
                SEND_DATA: begin
                    if (!i_tx_busy) begin
                        tx_dv_d   = 1'b1;
                        tx_byte_d = data_q;
                        state_d   = WAIT_DATA;
                    end
                end
`ifdef RESPONSE_PACKER_CHECKSUM_EN
                SEND_CHK: begin
                    if (!i_tx_busy) begin
                        tx_dv_d   = 1'b1;
                        tx_byte_d = code_q ^ data_q;
                        state_d   = WAIT_CHK;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end

        // Pending slot. In IDLE with an empty slot the result was latched above.
        // In IDLE with a full slot the slot is being drained this cycle, so the
        // new result can take its place without loss.
        if (new_vld && !(state_q == IDLE && !slot_vld_q)) begin
            if (!slot_vld_q || state_q == IDLE) begin
                slot_vld_d  = 1'b1;
                slot_code_d = enc_code;
                slot_data_d = enc_data;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= IDLE;
            code_q      <= '0;
            data_q      <= '0;
            slot_vld_q  <= 1'b0;
            slot_code_q <= '0;
            slot_data_q <= '0;
            cnt_q       <= '0;
            tx_dv_q     <= 1'b0;
            tx_byte_q   <= '0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            data_q      <= data_d;
            slot_vld_q  <= slot_vld_d;
            slot_code_q <= slot_code_d;
            slot_data_q <= slot_data_d;
            cnt_q       <= cnt_d;
            tx_dv_q     <= tx_dv_d;
            tx_byte_q   <= tx_byte_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
        end
    end

    assign o_tx_dv   = tx_dv_q;
    assign o_tx_byte = tx_byte_q;
    assign o_overrun = overrun_q;
    assign o_timeout = timeout_q;
    assign o_busy    = (state_q != IDLE) || slot_vld_q;

endmodule

// File: tb/tb_response_packer.sv
// Purpose: directed self-checking bench for response_packer with a small UART responder model.
// Latency: n/a.
// Backpressure: the UART model holds i_tx_busy for 4 cycles per byte, then pulses i_tx_done.
module tb_response_packer;

    logic       i_Clock;
    logic       i_Rst_n;
    logic       i_done;
    logic [5:0] i_comandos;
    logic [7:0] i_data;
    logic       i_tx_busy;
    logic       i_tx_done;
    logic       o_tx_dv;
    logic [7:0] o_tx_byte;
    logic       o_busy;
    logic       o_overrun;
    logic       o_timeout;

    response_packer #(.TIMEOUT_CYCLES(16), .CNT_W(23)) dut (
        .i_Clock    (i_Clock),
        .i_Rst_n    (i_Rst_n),
        .i_done     (i_done),
        .i_comandos (i_comandos),
        .i_data     (i_data),
        .i_tx_busy  (i_tx_busy),
        .i_tx_done  (i_tx_done),
        .o_tx_dv    (o_tx_dv),
        .o_tx_byte  (o_tx_byte),
        .o_busy     (o_busy),
        .o_overrun  (o_overrun),
        .o_timeout  (o_timeout)
    );

    initial begin
        i_Clock = 1'b0;
        forever #5 i_Clock = ~i_Clock;
    end

    // UART responder
    int   uart_cnt   = 0;
    logic uart_done  = 1'b0;
    logic uart_mute  = 1'b0;
    logic hold_busy  = 1'b0;
    logic stray_done = 1'b0;

    always @(posedge i_Clock) begin
        #1;
        uart_done = 1'b0;
        if (uart_cnt > 0) begin
            uart_cnt = uart_cnt - 1;
            if (uart_cnt == 0) uart_done = !uart_mute;
        end
        if (o_tx_dv) uart_cnt = 4;
    end

    assign i_tx_busy = (uart_cnt != 0) || hold_busy;
    assign i_tx_done = uart_done || stray_done;

    // Output monitor
    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];
    int dv_run = 0, dv_max = 0, ovr_cnt = 0, to_cnt = 0;

    always @(negedge i_Clock) begin
        if (o_tx_dv) begin
            tx_q.push_back(o_tx_byte);
            dv_run = dv_run + 1;
        end else begin
            dv_run = 0;
        end
        if (dv_run > dv_max) dv_max = dv_run;
        if (o_overrun) ovr_cnt = ovr_cnt + 1;
        if (o_timeout) to_cnt = to_cnt + 1;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_Clock);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [5:0] cmd, input logic [7:0] dat);
        i_comandos = cmd;
        i_data     = dat;
        i_done     = 1'b1;
        tick();
        i_done     = 1'b0;
        i_comandos = 6'b0;
    endtask

    task automatic add_exp(input logic [7:0] code, input logic [7:0] dat, input logic [7:0] chk_b);
        exp_q.push_back(code);
        exp_q.push_back(dat);
`ifdef RESPONSE_PACKER_CHECKSUM_EN
        exp_q.push_back(chk_b);
`else
        if (chk_b == 8'h00) begin end
`endif
    endtask

    task automatic check_bytes(input string tag);
        int n;
        chk({tag, "_count"}, tx_q.size(), exp_q.size());
        n = (tx_q.size() < exp_q.size()) ? tx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_byte"}, {24'h0, tx_q[i]}, {24'h0, exp_q[i]});
        tx_q.delete();
        exp_q.delete();
    endtask

    // Selector table: selector, payload, expected code, expected data byte, expected checksum
    logic [5:0] t_cmd [8] = '{6'b000001, 6'b000101, 6'b000110, 6'b000010,
                              6'b000100, 6'b010000, 6'b100000, 6'b110000};
    logic [7:0] t_dat [8] = '{8'h3C, 8'h5A, 8'h77, 8'h11, 8'h3C, 8'h80, 8'hFE, 8'h12};
    logic [7:0] t_code[8] = '{8'h1F, 8'h1F, 8'hFF, 8'h07, 8'h09, 8'h0A, 8'h0B, 8'hFF};
    logic [7:0] t_out [8] = '{8'h3C, 8'h5A, 8'h00, 8'h11, 8'h3C, 8'h80, 8'hFE, 8'h00};
    logic [7:0] t_chk [8] = '{8'h23, 8'h45, 8'hFF, 8'h16, 8'h35, 8'h8A, 8'hF5, 8'hFF};

    initial begin
        int k;
        i_Rst_n    = 1'b0;
        i_done     = 1'b0;
        i_comandos = 6'b0;
        i_data     = 8'h00;
        #1;
        chk("rst_tx_dv",   o_tx_dv,   0);
        chk("rst_tx_byte", o_tx_byte, 0);
        chk("rst_busy",    o_busy,    0);
        chk("rst_overrun", o_overrun, 0);
        chk("rst_timeout", o_timeout, 0);
        run(3);
        i_Rst_n = 1'b1;
        run(2);

        // Basic frame with latency check
        send(6'b001000, 8'h19);
        chk("lat_dv_cycle1", o_tx_dv, 0);
        tick();
        chk("lat_dv_cycle2", o_tx_dv, 1);
        chk("lat_byte0", o_tx_byte, 8'h08);
        run(40);
        add_exp(8'h08, 8'h19, 8'h11);
        check_bytes("frame_a");
`ifdef RESPONSE_PACKER_CHECKSUM_EN
        chk("byte_hold", o_tx_byte, 8'h11);
`else
        chk("byte_hold", o_tx_byte, 8'h19);
`endif
        chk("frame_a_timeout", to_cnt, 0);
        chk("frame_a_idle", o_busy, 0);

        // Selector mapping table
        for (int i = 0; i < 8; i++) begin
            send(t_cmd[i], t_dat[i]);
            run(40);
            add_exp(t_code[i], t_out[i], t_chk[i]);
            check_bytes("encode");
        end

        // Zero selector: no frame, no overrun
        send(6'b000000, 8'h55);
        run(10);
        check_bytes("zero_sel");
        chk("zero_sel_busy", o_busy, 0);
        chk("zero_sel_ovr", ovr_cnt, 0);

        // Transmitter busy holds SEND_CODE
        hold_busy = 1'b1;
        send(6'b001000, 8'h42);
        run(5);
        chk("hold_no_dv", tx_q.size(), 0);
        chk("hold_busy_out", o_busy, 1);
        hold_busy = 1'b0;
        run(40);
        add_exp(8'h08, 8'h42, 8'h4A);
        check_bytes("hold_frame");

        // Three results during one frame
        send(6'b000010, 8'h11);
        run(3);
        send(6'b010000, 8'h22);
        chk("ovr_none_yet", o_overrun, 0);
        run(2);
        send(6'b100000, 8'h33);
        chk("ovr_pulse", o_overrun, 1);
        tick();
        chk("ovr_one_cycle", o_overrun, 0);
        run(100);
        add_exp(8'h07, 8'h11, 8'h16);
        add_exp(8'h0A, 8'h22, 8'h28);
        check_bytes("ovr_frames");
        chk("ovr_count", ovr_cnt, 1);
        chk("ovr_idle", o_busy, 0);

        // Timeout with i_tx_done withheld after byte0
        uart_mute = 1'b1;
        send(6'b000010, 8'h44);
        tick();
        chk("to_dv", o_tx_dv, 1);
        k = 0;
        while (!o_timeout && k < 40) begin
            tick();
            k = k + 1;
        end
        chk("to_cycle", k, 16);
        chk("to_idle", o_busy, 0);
        tick();
        chk("to_one_cycle", o_timeout, 0);
        run(30);
        exp_q.push_back(8'h07);
        check_bytes("to_frame");
        chk("to_count", to_cnt, 1);
        uart_mute = 1'b0;
        run(5);

        // Stray i_tx_done in IDLE is ignored
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        run(5);
        chk("stray_busy", o_busy, 0);
        check_bytes("stray");

        // Reset during WAIT_DATA with the slot full
        send(6'b000010, 8'h11);
        run(3);
        send(6'b010000, 8'h22);
        k = 0;
        while (tx_q.size() < 2 && k < 60) begin
            tick();
            k = k + 1;
        end
        chk("rst_reach_wait_data", tx_q.size() >= 2, 1);
        chk("rst_pre_busy", o_busy, 1);
        i_Rst_n = 1'b0;
        #1;
        chk("mid_rst_tx_dv",   o_tx_dv,   0);
        chk("mid_rst_tx_byte", o_tx_byte, 0);
        chk("mid_rst_busy",    o_busy,    0);
        chk("mid_rst_overrun", o_overrun, 0);
        chk("mid_rst_timeout", o_timeout, 0);
        run(2);
        i_Rst_n = 1'b1;
        tx_q.delete();
        run(60);
        check_bytes("post_rst_no_pending");
        chk("post_rst_idle", o_busy, 0);

        // First result after reset release
        send(6'b100000, 8'hA5);
        run(40);
        add_exp(8'h0B, 8'hA5, 8'hAE);
        check_bytes("post_rst_frame");

        chk("dv_width", dv_max, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
